// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings, win-line table and FSM states for the tic-tac-toe engine
package ttt_pkg;
  localparam logic [1:0] ST_PLAY  = 2'b00;
  localparam logic [1:0] ST_X_WIN = 2'b01;
  localparam logic [1:0] ST_O_WIN = 2'b10;
  localparam logic [1:0] ST_DRAW  = 2'b11;
  localparam logic [3:0] CENTER_CELL = 4'd4;
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  typedef enum logic [1:0] {PLAY, CHECK, OVER} fsm_t;
endpackage

// File: rtl/ttt_line_checker.sv
// ttt_line_checker: flags every line fully held by player (combinational, reused by the renderer)
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [8:0] occupied,
  input  logic [8:0] owner,
  input  logic       player,
  output logic [7:0] win_line
);
  logic [8:0] mine;
  assign mine = occupied & (player ? owner : ~owner);
  for (genvar l = 0; l < 8; l++) begin : g_line
    assign win_line[l] = mine[LINES[l][0]] & mine[LINES[l][1]] & mine[LINES[l][2]];
  end
endmodule

// File: rtl/ttt_game_engine.sv
// ttt_game_engine: frame-paced tic-tac-toe engine with edge-detected buttons, wrapping cursor and win/draw detection
module ttt_game_engine
  import ttt_pkg::*;
#(
  parameter int OVER_HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pad_present,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_a,
  input  logic       btn_start,
  output logic [8:0] occupied,
  output logic [8:0] owner,
  output logic [3:0] cursor,
  output logic       turn,
  output logic [1:0] status,
  output logic [7:0] win_line,
  output logic [3:0] move_count
);
  localparam logic [7:0] HOLD = 8'(OVER_HOLD_FRAMES);
  fsm_t state, state_n;
  logic [5:0] btn, hist, press;
  logic [8:0] occupied_n, owner_n;
  logic [3:0] cursor_n, move_count_n;
  logic turn_n, col0, col2, done;
  logic [1:0] status_n;
  logic [7:0] win_line_n, lines, hold, hold_n;
  assign btn = pad_present ? {btn_start, btn_a, btn_up, btn_down, btn_left, btn_right} : '0;
  assign press = frame_tick ? btn & ~hist : '0;
  assign col0 = cursor == 4'd0 || cursor == 4'd3 || cursor == 4'd6;
  assign col2 = cursor == 4'd2 || cursor == 4'd5 || cursor == 4'd8;
  assign done = |lines || move_count == 4'd9;
  ttt_line_checker u_chk (.occupied(occupied), .owner(owner), .player(turn), .win_line(lines));
  always_comb begin
    state_n = state;
    occupied_n = occupied;
    owner_n = owner;
    cursor_n = cursor;
    turn_n = turn;
    status_n = status;
    win_line_n = win_line;
    move_count_n = move_count;
    hold_n = hold;
    if (press[5] && (state == PLAY || (state == OVER && hold == HOLD))) begin
      state_n = PLAY;
      occupied_n = '0;
      owner_n = '0;
      cursor_n = CENTER_CELL;
      turn_n = 1'b0;
      status_n = ST_PLAY;
      win_line_n = '0;
      move_count_n = '0;
      hold_n = '0;
    end else if (state == PLAY && press[4]) begin
      if (!occupied[cursor]) begin
        occupied_n[cursor] = 1'b1;
        owner_n[cursor] = turn;
        move_count_n = move_count + 4'd1;
        state_n = CHECK;
      end
    end else if (state == PLAY) begin
      cursor_n = press[3] ? (cursor < 4'd3 ? cursor + 4'd6 : cursor - 4'd3) :
                 press[2] ? (cursor > 4'd5 ? cursor - 4'd6 : cursor + 4'd3) :
                 press[1] ? (col0 ? cursor + 4'd2 : cursor - 4'd1) :
                 press[0] ? (col2 ? cursor - 4'd2 : cursor + 4'd1) : cursor;
    end else if (state == CHECK) begin
      state_n = done ? OVER : PLAY;
      win_line_n = lines;
      status_n = |lines ? (turn ? ST_O_WIN : ST_X_WIN) : done ? ST_DRAW : ST_PLAY;
      turn_n = done ? turn : ~turn;
      hold_n = '0;
    end else if (frame_tick && hold != HOLD) begin
      hold_n = hold + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PLAY;
      hist <= '1;
      occupied <= '0;
      owner <= '0;
      cursor <= CENTER_CELL;
      turn <= 1'b0;
      status <= ST_PLAY;
      win_line <= '0;
      move_count <= '0;
      hold <= '0;
    end else begin
      state <= state_n;
      if (frame_tick) hist <= btn;
      occupied <= occupied_n;
      owner <= owner_n;
      cursor <= cursor_n;
      turn <= turn_n;
      status <= status_n;
      win_line <= win_line_n;
      move_count <= move_count_n;
      hold <= hold_n;
    end
  end
endmodule

// File: tb/tb_ttt_game_engine.sv
// tb_ttt_game_engine: table-driven scenarios plus randomized play against a board-level reference model
module tb_ttt_game_engine;
  localparam int HOLD = 3;
  localparam logic [5:0] B_S = 6'b100000, B_A = 6'b010000, B_U = 6'b001000;
  localparam logic [5:0] B_D = 6'b000100, B_L = 6'b000010, B_R = 6'b000001, B_N = 6'b000000;
  typedef struct packed {
    logic [5:0] b;
    logic [3:0] cur;
    logic [8:0] occ;
    logic [8:0] own;
    logic       trn;
    logic [1:0] st;
    logic [7:0] wl;
    logic [3:0] mc;
  } vec_t;
  logic clk = 1'b0, rst_n, frame_tick, pad_present;
  logic btn_up, btn_down, btn_left, btn_right, btn_a, btn_start;
  logic [8:0] occupied, owner;
  logic [3:0] cursor, move_count;
  logic turn;
  logic [1:0] status;
  logic [7:0] win_line;
  int n_chk = 0, n_pass = 0;
  vec_t tbl[$];
  int m_cell[9];
  int m_row, m_col, m_turn, m_status, m_mc, m_cnt;
  logic [7:0] m_wl;
  bit m_over;
  logic [5:0] m_hist;
  int LN[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always #5 clk = ~clk;

  ttt_game_engine #(.OVER_HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pad_present(pad_present),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_a(btn_a), .btn_start(btn_start), .occupied(occupied), .owner(owner),
    .cursor(cursor), .turn(turn), .status(status), .win_line(win_line), .move_count(move_count)
  );

  function automatic vec_t mk(input logic [5:0] b, input logic [3:0] cur, input logic [8:0] occ,
                              input logic [8:0] own, input logic trn, input logic [1:0] st,
                              input logic [7:0] wl, input logic [3:0] mc);
    return '{b, cur, occ, own, trn, st, wl, mc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] cur, input logic [8:0] occ,
                         input logic [8:0] own, input logic trn, input logic [1:0] st,
                         input logic [7:0] wl, input logic [3:0] mc);
    chk({tag, " cursor"}, 32'(cursor), 32'(cur));
    chk({tag, " occupied"}, 32'(occupied), 32'(occ));
    chk({tag, " owner"}, 32'(owner), 32'(own));
    chk({tag, " turn"}, 32'(turn), 32'(trn));
    chk({tag, " status"}, 32'(status), 32'(st));
    chk({tag, " win_line"}, 32'(win_line), 32'(wl));
    chk({tag, " move_count"}, 32'(move_count), 32'(mc));
  endtask

  task automatic drive(input logic [5:0] b, input logic pad);
    {btn_start, btn_a, btn_up, btn_down, btn_left, btn_right} = b;
    pad_present = pad;
  endtask

  // Leaves the bench on the negedge two cycles after the tick edge
  task automatic tick(input logic [5:0] b, input logic pad);
    @(negedge clk);
    drive(b, pad);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] m_lines(input int who);
    logic [7:0] r;
    r = '0;
    for (int l = 0; l < 8; l++)
      r[l] = m_cell[LN[l][0]] == who && m_cell[LN[l][1]] == who && m_cell[LN[l][2]] == who;
    return r;
  endfunction

  task automatic m_new();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_row = 1; m_col = 1; m_turn = 0; m_status = 0; m_mc = 0; m_cnt = 0;
    m_wl = '0; m_over = 1'b0;
  endtask

  task automatic m_step(input logic [5:0] b);
    logic [5:0] p;
    logic [7:0] wl;
    int cur;
    p = b & ~m_hist;
    m_hist = b;
    cur = 3 * m_row + m_col;
    if (m_over) begin
      if (p[5] && m_cnt == HOLD) m_new();
      else if (m_cnt < HOLD) m_cnt++;
    end else if (p[5]) m_new();
    else if (p[4]) begin
      if (m_cell[cur] == 0) begin
        m_cell[cur] = m_turn + 1;
        m_mc++;
        wl = m_lines(m_turn + 1);
        if (wl != 0) begin
          m_over = 1'b1; m_wl = wl; m_status = m_turn ? 2 : 1; m_cnt = 0;
        end else if (m_mc == 9) begin
          m_over = 1'b1; m_status = 3; m_cnt = 0;
        end else m_turn = 1 - m_turn;
      end
    end else if (p[3]) m_row = (m_row + 2) % 3;
    else if (p[2]) m_row = (m_row + 1) % 3;
    else if (p[1]) m_col = (m_col + 2) % 3;
    else if (p[0]) m_col = (m_col + 1) % 3;
  endtask

  task automatic chk_model(input string tag);
    logic [8:0] o, w;
    for (int i = 0; i < 9; i++) begin
      o[i] = m_cell[i] != 0;
      w[i] = m_cell[i] == 2;
    end
    chk_all(tag, 4'(3 * m_row + m_col), o, w, 1'(m_turn), 2'(m_status), m_wl, 4'(m_mc));
  endtask

  initial begin
    // cursor walk, cross wins on the top row, OVER hold, then a full-board draw
    for (int i = 0; i < 3; i++) tbl.push_back(mk(B_A, 4, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_N, 4, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_L, 3, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_N, 3, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_L, 5, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_N, 5, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_U, 2, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_N, 2, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_U, 8, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_N, 8, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_R, 6, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_D, 0, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_A, 0, 9'h001, 9'h000, 1, 0, 0, 1));
    tbl.push_back(mk(B_D, 3, 9'h001, 9'h000, 1, 0, 0, 1));
    tbl.push_back(mk(B_A, 3, 9'h009, 9'h008, 0, 0, 0, 2));
    tbl.push_back(mk(B_U, 0, 9'h009, 9'h008, 0, 0, 0, 2));
    tbl.push_back(mk(B_R, 1, 9'h009, 9'h008, 0, 0, 0, 2));
    tbl.push_back(mk(B_A, 1, 9'h00B, 9'h008, 1, 0, 0, 3));
    tbl.push_back(mk(B_D, 4, 9'h00B, 9'h008, 1, 0, 0, 3));
    tbl.push_back(mk(B_A, 4, 9'h01B, 9'h018, 0, 0, 0, 4));
    tbl.push_back(mk(B_U, 1, 9'h01B, 9'h018, 0, 0, 0, 4));
    tbl.push_back(mk(B_R, 2, 9'h01B, 9'h018, 0, 0, 0, 4));
    tbl.push_back(mk(B_A, 2, 9'h01F, 9'h018, 0, 1, 8'h01, 5));
    tbl.push_back(mk(B_N, 2, 9'h01F, 9'h018, 0, 1, 8'h01, 5));
    tbl.push_back(mk(B_S, 2, 9'h01F, 9'h018, 0, 1, 8'h01, 5));
    tbl.push_back(mk(B_A, 2, 9'h01F, 9'h018, 0, 1, 8'h01, 5));
    tbl.push_back(mk(B_L, 2, 9'h01F, 9'h018, 0, 1, 8'h01, 5));
    tbl.push_back(mk(B_S, 4, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_U, 1, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_L, 0, 9'h000, 9'h000, 0, 0, 0, 0));
    tbl.push_back(mk(B_A, 0, 9'h001, 9'h000, 1, 0, 0, 1));
    tbl.push_back(mk(B_R, 1, 9'h001, 9'h000, 1, 0, 0, 1));
    tbl.push_back(mk(B_A, 1, 9'h003, 9'h002, 0, 0, 0, 2));
    tbl.push_back(mk(B_R, 2, 9'h003, 9'h002, 0, 0, 0, 2));
    tbl.push_back(mk(B_A, 2, 9'h007, 9'h002, 1, 0, 0, 3));
    tbl.push_back(mk(B_D, 5, 9'h007, 9'h002, 1, 0, 0, 3));
    tbl.push_back(mk(B_L, 4, 9'h007, 9'h002, 1, 0, 0, 3));
    tbl.push_back(mk(B_A, 4, 9'h017, 9'h012, 0, 0, 0, 4));
    tbl.push_back(mk(B_L, 3, 9'h017, 9'h012, 0, 0, 0, 4));
    tbl.push_back(mk(B_A, 3, 9'h01F, 9'h012, 1, 0, 0, 5));
    tbl.push_back(mk(B_N, 3, 9'h01F, 9'h012, 1, 0, 0, 5));
    tbl.push_back(mk(B_A, 3, 9'h01F, 9'h012, 1, 0, 0, 5));
    tbl.push_back(mk(B_R, 4, 9'h01F, 9'h012, 1, 0, 0, 5));
    tbl.push_back(mk(B_N, 4, 9'h01F, 9'h012, 1, 0, 0, 5));
    tbl.push_back(mk(B_R, 5, 9'h01F, 9'h012, 1, 0, 0, 5));
    tbl.push_back(mk(B_A, 5, 9'h03F, 9'h032, 0, 0, 0, 6));
    tbl.push_back(mk(B_D, 8, 9'h03F, 9'h032, 0, 0, 0, 6));
    tbl.push_back(mk(B_L, 7, 9'h03F, 9'h032, 0, 0, 0, 6));
    tbl.push_back(mk(B_A, 7, 9'h0BF, 9'h032, 1, 0, 0, 7));
    tbl.push_back(mk(B_L, 6, 9'h0BF, 9'h032, 1, 0, 0, 7));
    tbl.push_back(mk(B_A, 6, 9'h0FF, 9'h072, 0, 0, 0, 8));
    tbl.push_back(mk(B_R, 7, 9'h0FF, 9'h072, 0, 0, 0, 8));
    tbl.push_back(mk(B_N, 7, 9'h0FF, 9'h072, 0, 0, 0, 8));
    tbl.push_back(mk(B_R, 8, 9'h0FF, 9'h072, 0, 0, 0, 8));
    tbl.push_back(mk(B_N, 8, 9'h0FF, 9'h072, 0, 0, 0, 8));
    tbl.push_back(mk(B_A | B_R, 8, 9'h1FF, 9'h072, 0, 3, 0, 9));

    drive(B_A, 1'b1);
    frame_tick = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_all("reset", 4, 9'h000, 9'h000, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      tick(tbl[i].b, 1'b1);
      chk_all($sformatf("vec%0d", i), tbl[i].cur, tbl[i].occ, tbl[i].own, tbl[i].trn,
              tbl[i].st, tbl[i].wl, tbl[i].mc);
    end

    // start on the first OVER tick is ignored, on the fifth it starts a new game
    tick(B_S, 1'b1);
    chk("over_early_start status", 32'(status), 32'd3);
    chk("over_early_start occupied", 32'(occupied), 32'h1FF);
    repeat (3) tick(B_N, 1'b1);
    tick(B_S, 1'b1);
    chk_all("over_restart", 4, 9'h000, 9'h000, 0, 0, 0, 0);

    // board updates one cycle after the tick, turn one cycle later
    @(negedge clk);
    drive(B_A, 1'b1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("t1 occupied", 32'(occupied), 32'h010);
    chk("t1 move_count", 32'(move_count), 32'd1);
    chk("t1 turn", 32'(turn), 32'd0);
    @(negedge clk);
    chk("t2 turn", 32'(turn), 32'd1);
    chk("t2 status", 32'(status), 32'd0);

    // reset landing on the CHECK cycle, then a held button must not place
    tick(B_R, 1'b1);
    chk("pre_rst cursor", 32'(cursor), 32'd5);
    @(negedge clk);
    drive(B_A, 1'b1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    rst_n = 1'b0;
    chk("pre_rst occupied", 32'(occupied), 32'h030);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all("rst_in_check", 4, 9'h000, 9'h000, 0, 0, 0, 0);
    tick(B_A, 1'b1);
    chk("held_a occupied", 32'(occupied), 32'h000);
    chk("held_a move_count", 32'(move_count), 32'd0);

    // randomized play against the model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_new();
    m_hist = '1;
    for (int n = 0; n < 800; n++) begin
      logic [5:0] raw;
      logic pad;
      raw[5] = $urandom_range(15) == 0;
      raw[4:0] = 5'($urandom_range(31) & $urandom_range(31));
      pad = $urandom_range(9) != 0;
      tick(raw, pad);
      m_step(pad ? raw : 6'b0);
      chk_model($sformatf("rand%0d", n));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ttt_game_engine.md
# ttt_game_engine

Frame-paced tic-tac-toe game engine between the gamepad PMOD decoder (upstream) and the VGA renderer (downstream). It samples decoded buttons once per video frame, detects press edges, and moves a 3x3 wrapping cursor. It places marks for alternating players, detects all eight win lines and the draw condition, and exports a stable board/status image. The renderer reads that image combinationally during active video.

## Interface
Parameters:
- OVER_HOLD_FRAMES, default 60: frame ticks spent in OVER before start is honoured (range 0..255).

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-cycle pulse per frame (start of vblank); the only instant buttons are sampled
- pad_present  in  1  gamepad detected; 0 forces all buttons to 0
- btn_up, btn_down, btn_left, btn_right  in  1 each  decoded d-pad levels
- btn_a  in  1  place mark
- btn_start  in  1  new game
- occupied  out  9  cell i holds a mark (row-major, i = 3*row + col)
- owner  out  9  mark type per cell: 0 cross, 1 circle; 0 when unoccupied
- cursor  out  4  selected cell 0..8
- turn  out  1  player to move: 0 cross, 1 circle
- status  out  2  00 playing, 01 cross won, 10 circle won, 11 draw
- win_line  out  8  completed lines: bits 0-2 rows, 3-5 columns, 6 main diagonal (0,4,8), 7 anti-diagonal (2,4,6)
- move_count  out  4  marks placed, 0..9

## Operation
- Reset values: occupied=0, owner=0, cursor=4, turn=0, status=00, win_line=0, move_count=0. Internal state: PLAY, button history all-ones, hold counter 0.
- Edge detection: on frame_tick, press = btn & ~hist, then hist <= btn. The all-ones reset history means a button held through reset never counts as a press.
- History updates on every tick in every state. Press edges are only acted on in the state that consumes them.
- Per tick, act on at most one press, in priority order: start > a > up > down > left > right.
- PLAY, start press: new game. Clear all outputs to their reset values and stay in PLAY.
- PLAY, a press on an empty cursor cell: set occupied[cursor]=1 and owner[cursor]=turn, increment move_count, go to CHECK.
- PLAY, a press on an occupied cell: no change.
- PLAY, movement: wraps within the row or column. left: col 0 -> col 2. right: col 2 -> col 0. up: row 0 -> row 2. down: row 2 -> row 0.
- CHECK lasts exactly one cycle. It evaluates all 8 lines for the player `turn`.
- CHECK with any line complete: win_line = all complete lines (may be 2 bits), status = turn ? 10 : 01, go to OVER, clear hold counter. turn is unchanged.
- CHECK with no line and move_count == 9: status = 11, go to OVER. A win on the ninth move takes priority over draw.
- CHECK otherwise: toggle turn, return to PLAY.
- OVER: board frozen; movement and a presses ignored. Each tick increments the hold counter, saturating at OVER_HOLD_FRAMES.
- OVER, start press: new game only if the counter equalled OVER_HOLD_FRAMES before this tick; otherwise ignored.
- A tick coinciding with the CHECK cycle: history updates, presses are discarded.

## Timing
- Tick at cycle T: cursor, occupied, owner and move_count are valid at T+1.
- Tick at T: status, win_line and turn are valid at T+2, from CHECK at T+1.
- New game from start: all outputs cleared at T+1.
- All outputs are registered and change only in the cycle after a tick or in the CHECK cycle. The renderer therefore sees at most one change per frame, during vblank.
- rst_n low at any time, including during CHECK: reset values on the next edge.

## Structure
- Shared package ttt_pkg holds:
  - status encodings (ST_PLAY, ST_X_WIN, ST_O_WIN, ST_DRAW);
  - the line table LINES[8] of cell triples;
  - CENTER_CELL = 4;
  - the FSM state enum (PLAY, CHECK, OVER).
- Sub-module ttt_line_checker, purely combinational: (occupied, owner, player) -> win_line[7:0]. The renderer reuses it for highlighting.
- Engine FSM, edge detector, cursor and hold counter live in ttt_game_engine.

## Test plan
- Reset with btn_a held, then 3 ticks -> no placement, cursor=4, occupied=0.
- From cursor 4: ticks with left, left, up, each a separate press -> cursor 3, 5, 2; one further up -> 8.
- Cross places 0, circle 3, cross 1, circle 4, cross 2 -> 2 cycles after the last tick status=01, win_line=0000_0001, turn=0. A further a press leaves the board unchanged.
- Fill the board as X O X / X O O / O X X, X moving first and the last move at cell 8 -> status=11, move_count=9, win_line=0.
- OVER_HOLD_FRAMES=3, start pressed on tick 1 of OVER -> ignored. Start pressed again (release between presses) on tick 5 -> board cleared, status=00, cursor=4.
- a pressed on an occupied cell -> move_count and turn unchanged. a and right on the same tick over an empty cell -> mark placed, cursor unchanged.
